// File: rtl/cpu_vector_player.sv
// Vector-ROM driven stimulus/check engine for the Simple_CPU front panel.
// Optional build macro: HALT_ON_ERROR_EN (stop the run at the first LED mismatch).
module cpu_vector_player #(
  parameter int WIDTH_OPCODE        = 4,
  parameter int WIDTH_SWITCH_LENGTH = 6,
  parameter int ADDR_WIDTH          = 10,
  parameter int SETTLE_CYCLES       = 2
) (
  input  logic                                          clk,
  input  logic                                          Rstn,
  input  logic                                          Start,
  input  logic [ADDR_WIDTH:0]                           NumVectors,
  output logic [ADDR_WIDTH-1:0]                         RomAddr,
  input  logic [WIDTH_OPCODE+WIDTH_SWITCH_LENGTH+9:0]   RomData,
  output logic [WIDTH_OPCODE-1:0]                       OpcodeInput,
  output logic [WIDTH_SWITCH_LENGTH-1:0]                ExternalSwitch,
  output logic                                          Execute,
  output logic                                          CpuRstn,
  input  logic [7:0]                                    LED,
  output logic                                          Busy,
  output logic                                          Done,
  output logic [15:0]                                   ErrorCount,
  output logic                                          FirstErrValid,
  output logic [ADDR_WIDTH-1:0]                         FirstErrAddr,
  output logic [2:0]                                    DbgState
);

  localparam int VEC_W = WIDTH_OPCODE + WIDTH_SWITCH_LENGTH + 10;
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0] MAX_VEC = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                          r_state;
  logic [ADDR_WIDTH:0]             r_num;
  logic [ADDR_WIDTH:0]             r_idx;
  logic [SW-1:0]                   r_settle;
  logic [7:0]                      r_exp;
  logic [ADDR_WIDTH-1:0]           r_rom_addr;
  logic [WIDTH_OPCODE-1:0]         r_opcode;
  logic [WIDTH_SWITCH_LENGTH-1:0]  r_switch;
  logic                            r_execute;
  logic                            r_cpu_rstn;
  logic                            r_busy;
  logic                            r_done;
  logic [15:0]                     r_err;
  logic                            r_fev;
  logic [ADDR_WIDTH-1:0]           r_fea;

  logic [ADDR_WIDTH:0]             w_num_clamped;
  logic [ADDR_WIDTH:0]             w_idx_next;
  logic                            w_mismatch;
  logic                            w_halt;
  logic                            w_last;

  // Requests beyond the ROM depth are clamped so the index can never wrap.
  assign w_num_clamped = (NumVectors > MAX_VEC) ? MAX_VEC : NumVectors;
  assign w_idx_next    = r_idx + 1'b1;
  assign w_mismatch    = (LED != r_exp);
  assign w_last        = (w_idx_next == r_num);

`ifdef HALT_ON_ERROR_EN
  assign w_halt = w_mismatch;
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!Rstn) begin
      r_state    <= S_IDLE;
      r_num      <= '0;
      r_idx      <= '0;
      r_settle   <= '0;
      r_exp      <= '0;
      r_rom_addr <= '0;
      r_opcode   <= '0;
      r_switch   <= '0;
      r_execute  <= 1'b0;
      r_cpu_rstn <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= '0;
      r_fev      <= 1'b0;
      r_fea      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_num  <= w_num_clamped;
            r_idx  <= '0;
            r_err  <= '0;
            r_fev  <= 1'b0;
            r_fea  <= '0;
            if (w_num_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_done     <= 1'b0;
              r_busy     <= 1'b1;
              r_rom_addr <= '0;
            end
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_opcode   <= RomData[VEC_W-1 -: WIDTH_OPCODE];
          r_switch   <= RomData[VEC_W-WIDTH_OPCODE-1 -: WIDTH_SWITCH_LENGTH];
          r_execute  <= RomData[9];
          r_cpu_rstn <= RomData[8];
          r_exp      <= RomData[7:0];
          r_settle   <= SW'(SETTLE_CYCLES - 1);
          r_state    <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == '0) r_state <= S_CHECK;
          else                r_settle <= r_settle - 1'b1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            if (!r_fev) begin
              r_fev <= 1'b1;
              r_fea <= r_idx[ADDR_WIDTH-1:0];
            end
          end
          r_idx <= w_idx_next;
          if (w_halt || w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_rom_addr <= w_idx_next[ADDR_WIDTH-1:0];
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign RomAddr        = r_rom_addr;
  assign OpcodeInput    = r_opcode;
  assign ExternalSwitch = r_switch;
  assign Execute        = r_execute;
  assign CpuRstn        = r_cpu_rstn;
  assign Busy           = r_busy;
  assign Done           = r_done;
  assign ErrorCount     = r_err;
  assign FirstErrValid  = r_fev;
  assign FirstErrAddr   = r_fea;
  assign DbgState       = r_state;

endmodule

// File: tb/tb_cpu_vector_player.sv
// Directed bench for cpu_vector_player: ROM model, toy CPU LED model, scoreboard checks.
module tb_cpu_vector_player;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [AW:0] num_vectors;
  logic [AW-1:0] rom_addr;
  logic [19:0] rom_data;
  logic [3:0]  opcode;
  logic [5:0]  ext_switch;
  logic        execute;
  logic        cpu_rstn;
  logic [7:0]  led;
  logic        busy;
  logic        done;
  logic [15:0] error_count;
  logic        first_err_valid;
  logic [AW-1:0] first_err_addr;
  logic [2:0]  dbg_state;

  logic [19:0] rom [0:(1<<AW)-1];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_vector_player dut (
    .clk(clk), .Rstn(rstn), .Start(start), .NumVectors(num_vectors),
    .RomAddr(rom_addr), .RomData(rom_data),
    .OpcodeInput(opcode), .ExternalSwitch(ext_switch), .Execute(execute), .CpuRstn(cpu_rstn),
    .LED(led), .Busy(busy), .Done(done), .ErrorCount(error_count),
    .FirstErrValid(first_err_valid), .FirstErrAddr(first_err_addr), .DbgState(dbg_state)
  );

  // Synchronous ROM and a toy CPU whose LED bus is a fixed function of its panel inputs.
  always_ff @(posedge clk) rom_data <= rom[rom_addr];
  assign led = cpu_rstn ? ({opcode, ext_switch[3:0]} ^ 8'hF7) : 8'h00;

  function automatic logic [19:0] mkvec(input logic [3:0] op, input logic [5:0] sw,
                                        input logic ex, input logic rs);
    logic [7:0] e;
    e = rs ? ({op, sw[3:0]} ^ 8'hF7) : 8'h00;
    return {op, sw, ex, rs, e};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_good_rom();
    for (int i = 0; i < (1 << AW); i++) rom[i] = 20'h0;
    rom[0] = mkvec(4'h1, 6'h05, 1'b1, 1'b1);
    rom[1] = mkvec(4'h3, 6'h1C, 1'b0, 1'b1);
    rom[2] = mkvec(4'h7, 6'h2A, 1'b1, 1'b0);
    rom[3] = mkvec(4'hC, 6'h3F, 1'b1, 1'b1);
    rom[4] = mkvec(4'h9, 6'h12, 1'b0, 1'b1);
  endtask

  // Pulses Start, counts posedges (Start edge = 1) until Done; -1 on timeout.
  task automatic run(input int n, input int budget, input int pulse_at, output int cycles);
    @(negedge clk);
    num_vectors = n[AW:0];
    start = 1'b1;
    cycles = 0;
    while (1) begin
      @(posedge clk);
      cycles++;
      #1;
      start = (cycles == pulse_at);
      if (done && cycles > 0 && !start) break;
      if (cycles >= budget) begin
        cycles = -1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int cyc;
    int found;
    logic [AW-1:0] saved_addr;
    rstn = 1'b0;
    start = 1'b0;
    num_vectors = '0;
    load_good_rom();
    do_reset();

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_errcnt", error_count, 0);
    check("rst_fev", first_err_valid, 0);
    check("rst_romaddr", rom_addr, 0);
    check("rst_cpurstn", cpu_rstn, 0);
    check("rst_opcode", opcode, 0);

    run(5, 100, 0, cyc);
    check("good_cycles", cyc, 26);
    check("good_errcnt", error_count, 0);
    check("good_fev", first_err_valid, 0);
    check("good_busy", busy, 0);
    check("good_hold_opcode", opcode, 4'h9);
    check("good_hold_switch", ext_switch, 6'h12);

    rom[1] = rom[1] ^ 20'h00001;
    rom[3] = rom[3] ^ 20'h00080;
    run(5, 100, 0, cyc);
`ifdef HALT_ON_ERROR_EN
    check("err_cycles", cyc, 11);
    check("err_errcnt", error_count, 1);
`else
    check("err_cycles", cyc, 26);
    check("err_errcnt", error_count, 2);
`endif
    check("err_fev", first_err_valid, 1);
    check("err_fea", first_err_addr, 1);

    load_good_rom();
    run(5, 100, 12, cyc);
    check("rerun_cycles_busy_start", cyc, 26);
    check("rerun_errcnt_cleared", error_count, 0);
    check("rerun_fev_cleared", first_err_valid, 0);
    check("rerun_fea_cleared", first_err_addr, 0);

    saved_addr = rom_addr;
    run(0, 10, 0, cyc);
    check("zero_cycles", cyc, 1);
    check("zero_romaddr", rom_addr, saved_addr);
    check("zero_errcnt", error_count, 0);
    check("zero_busy", busy, 0);

    rom[0] = {4'hA, 6'h2B, 1'b1, 1'b1, 8'h5C};
    run(1, 20, 0, cyc);
    check("fields_cycles", cyc, 6);
    check("fields_opcode", opcode, 4'hA);
    check("fields_switch", ext_switch, 6'h2B);
    check("fields_execute", execute, 1);
    check("fields_cpurstn", cpu_rstn, 1);
    check("fields_errcnt", error_count, 0);

    for (int i = 0; i < (1 << AW); i++) rom[i] = 20'h0;
    run(2047, 6000, 0, cyc);
    check("clamp_cycles", cyc, 1024 * 5 + 1);
    check("clamp_romaddr", rom_addr, 10'h3FF);
    check("clamp_errcnt", error_count, 0);

    @(negedge clk);
    rstn = 1'b0;
    start = 1'b1;
    num_vectors = 11'd5;
    @(posedge clk);
    #1;
    check("rst_vs_start_state", dbg_state, 0);
    check("rst_vs_start_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    start = 1'b0;

    load_good_rom();
    @(negedge clk);
    num_vectors = 11'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (dbg_state == 3'd3 && rom_addr == 10'd3) begin
        found = 1;
        break;
      end
    end
    check("mid_reset_reached_settle", found, 1);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_state", dbg_state, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_opcode", opcode, 0);
    check("mid_reset_switch", ext_switch, 0);
    check("mid_reset_execute", execute, 0);
    check("mid_reset_cpurstn", cpu_rstn, 0);
    check("mid_reset_romaddr", rom_addr, 0);
    check("mid_reset_errcnt", error_count, 0);
    @(negedge clk);
    rstn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
